// File: rtl/line_buf_pkg.sv
// rtl/line_buf_pkg.sv - shared widths, FSM encoding and output triplet type for the line buffer
package line_buf_pkg;
  localparam int PIX_W        = 8;
  localparam int PIX_PER_WORD = 8;
  localparam int WORD_W       = PIX_W * PIX_PER_WORD;

  localparam logic [0:0] ST_PRIME  = 1'b0;
  localparam logic [0:0] ST_STREAM = 1'b1;

  typedef struct packed {
    logic [WORD_W-1:0] line1;
    logic [WORD_W-1:0] line2;
    logic [WORD_W-1:0] line3;
  } triplet_t;
endpackage

// File: rtl/line_ram.sv
// rtl/line_ram.sv - simple dual-port RAM, registered read with enable, read-before-write
module line_ram #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
    if (we) mem[waddr] <= wdata;
  end
endmodule

// File: rtl/line_triplet_buffer.sv
// rtl/line_triplet_buffer.sv - two-row line buffer emitting (r-2, r-1, r) word streams
// LB_TOP_PAD_EN: emit every row with top-border replication instead of priming two rows.
module line_triplet_buffer
  import line_buf_pkg::*;
#(
  parameter int IMG_WIDTH_WORDS = 64,
  parameter int IMG_HEIGHT      = 512,
  parameter int ADDR_W          = 6
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_data_valid,
  input  logic [WORD_W-1:0] i_data,
  output logic              o_data_ack,
  output logic              o_line1_data_valid,
  output logic [WORD_W-1:0] o_line1_data,
  input  logic              i_line1_data_ack,
  output logic              o_line2_data_valid,
  output logic [WORD_W-1:0] o_line2_data,
  input  logic              i_line2_data_ack,
  output logic              o_line3_data_valid,
  output logic [WORD_W-1:0] o_line3_data,
  input  logic              i_line3_data_ack,
  output logic              o_frame_done
);
  localparam int                ROW_W    = $clog2(IMG_HEIGHT);
  localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(IMG_WIDTH_WORDS - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

  logic              rst_n_q;
  logic [ADDR_W-1:0] col;
  logic [ROW_W-1:0]  row;
  logic              sel;
  logic              s1_valid, s1_sel, s1_last;
  logic [WORD_W-1:0] s1_data;
  logic              s2_valid, s2_last;
  logic [2:0]        taken;
  triplet_t          s2_q, s2_next;
  logic [WORD_W-1:0] ram_a_q, ram_b_q, rd_r1, rd_r2;
  logic              acc, emit, col_wrap, row_wrap, s2_done, s2_load;
  logic              frame_done_q;

  assign o_line1_data_valid = s2_valid & ~taken[0];
  assign o_line2_data_valid = s2_valid & ~taken[1];
  assign o_line3_data_valid = s2_valid & ~taken[2];
  assign o_line1_data       = s2_q.line1;
  assign o_line2_data       = s2_q.line2;
  assign o_line3_data       = s2_q.line3;
  assign o_frame_done       = frame_done_q;

  // Acks arriving in the completing cycle count, so S2 can reload on that same edge.
  assign s2_done = s2_valid & (taken[0] | i_line1_data_ack)
                            & (taken[1] | i_line2_data_ack)
                            & (taken[2] | i_line3_data_ack);
  assign s2_load    = s1_valid & (~s2_valid | s2_done);
  assign o_data_ack = rst_n_q & ~(s1_valid & s2_valid & ~s2_done);
  assign acc        = i_data_valid & o_data_ack;
  assign col_wrap   = (col == COL_LAST);
  assign row_wrap   = (row == ROW_LAST);

  // sel = 0: RAM A holds row r-1, RAM B holds row r-2; sel = 1 swaps them.
  line_ram #(.DEPTH(IMG_WIDTH_WORDS), .ADDR_W(ADDR_W), .DATA_W(WORD_W)) u_ram_a (
    .clk(i_clk), .we(acc & sel), .waddr(col), .wdata(i_data),
    .re(acc), .raddr(col), .rdata(ram_a_q)
  );
  line_ram #(.DEPTH(IMG_WIDTH_WORDS), .ADDR_W(ADDR_W), .DATA_W(WORD_W)) u_ram_b (
    .clk(i_clk), .we(acc & ~sel), .waddr(col), .wdata(i_data),
    .re(acc), .raddr(col), .rdata(ram_b_q)
  );

  assign rd_r1 = s1_sel ? ram_b_q : ram_a_q;
  assign rd_r2 = s1_sel ? ram_a_q : ram_b_q;

`ifdef LB_TOP_PAD_EN
  logic s1_pad0, s1_pad1;

  assign emit = 1'b1;

  always_comb begin
    s2_next.line3 = s1_data;
    s2_next.line2 = rd_r1;
    s2_next.line1 = rd_r2;
    if (s1_pad0) begin
      s2_next.line1 = s1_data;
      s2_next.line2 = s1_data;
    end else if (s1_pad1) begin
      s2_next.line1 = rd_r1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      s1_pad0 <= 1'b0;
      s1_pad1 <= 1'b0;
    end else if (acc) begin
      s1_pad0 <= (row == '0);
      s1_pad1 <= (row == ROW_W'(1));
    end
  end
`else
  logic [0:0] state;

  assign emit = (state == ST_STREAM);

  always_comb begin
    s2_next.line3 = s1_data;
    s2_next.line2 = rd_r1;
    s2_next.line1 = rd_r2;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state <= ST_PRIME;
    end else if (acc && col_wrap) begin
      if (row_wrap)                                 state <= ST_PRIME;
      else if (state == ST_PRIME && row == ROW_W'(1)) state <= ST_STREAM;
    end
  end
`endif

  always_ff @(posedge i_clk) begin
    rst_n_q <= i_rst;
    if (!i_rst) begin
      col          <= '0;
      row          <= '0;
      sel          <= 1'b0;
      s1_valid     <= 1'b0;
      s1_sel       <= 1'b0;
      s1_last      <= 1'b0;
      s1_data      <= '0;
      s2_valid     <= 1'b0;
      s2_last      <= 1'b0;
      s2_q         <= '0;
      taken        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= s2_done & s2_last;
      if (acc) begin
        s1_valid <= emit;
        s1_data  <= i_data;
        s1_sel   <= sel;
        s1_last  <= row_wrap & col_wrap;
        if (col_wrap) begin
          col <= '0;
          sel <= ~sel;
          row <= row_wrap ? '0 : row + ROW_W'(1);
        end else begin
          col <= col + ADDR_W'(1);
        end
      end else if (s2_load) begin
        s1_valid <= 1'b0;
      end
      if (s2_load) begin
        s2_valid <= 1'b1;
        s2_q     <= s2_next;
        s2_last  <= s1_last;
        taken    <= '0;
      end else if (s2_done) begin
        s2_valid <= 1'b0;
        taken    <= '0;
      end else begin
        taken <= taken | ({i_line3_data_ack, i_line2_data_ack, i_line1_data_ack}
                        & {o_line3_data_valid, o_line2_data_valid, o_line1_data_valid});
      end
    end
  end
endmodule
